// File: rtl/axis_hs_pkg.sv
// Shared mode constants, widths and the half-word transform used by axis_half_sum_fifo.
package axis_hs_pkg;

  localparam logic [1:0] AXIS_HS_MODE_PASS = 2'd0;
  localparam logic [1:0] AXIS_HS_MODE_ADD  = 2'd1;
  localparam logic [1:0] AXIS_HS_MODE_XOR  = 2'd2;

  localparam int AXIS_HS_STATS_W = 32;
  localparam int AXIS_HS_MAX_W   = 512;
  localparam int AXIS_HS_IDX_W   = $clog2(AXIS_HS_MAX_W);

  typedef logic [AXIS_HS_MAX_W-1:0] axis_hs_word_t;

  // data arrives zero-extended from the live stream width; width marks where the halves split
  function automatic axis_hs_word_t axis_hs_apply(input logic [1:0] mode,
                                                  input axis_hs_word_t data,
                                                  input int width);
    axis_hs_word_t res;
    logic carry;
    int half;
    half  = width / 2;
    res   = '0;
    carry = 1'b0;
    case (mode)
      AXIS_HS_MODE_ADD: begin
        for (int i = 0; i < AXIS_HS_MAX_W / 2; i++) begin
          if (i < half) begin
            res[AXIS_HS_IDX_W'(i)] = data[AXIS_HS_IDX_W'(i)] ^ data[AXIS_HS_IDX_W'(i + half)] ^ carry;
            carry = (data[AXIS_HS_IDX_W'(i)] & data[AXIS_HS_IDX_W'(i + half)]) |
                    (carry & (data[AXIS_HS_IDX_W'(i)] ^ data[AXIS_HS_IDX_W'(i + half)]));
          end
        end
        for (int i = 0; i < AXIS_HS_MAX_W; i++) begin
          if (i >= half && i < width) res[AXIS_HS_IDX_W'(i)] = carry;
        end
      end
      AXIS_HS_MODE_XOR: begin
        for (int i = 0; i < AXIS_HS_MAX_W / 2; i++) begin
          if (i < half)
            res[AXIS_HS_IDX_W'(i)] = data[AXIS_HS_IDX_W'(i)] ^ data[AXIS_HS_IDX_W'(i + half)];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axis_hs_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy output; DEPTH must be a power of two.
module axis_hs_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != FULL_LEVEL) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; the level register alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/axis_half_sum_fifo.sv
// AXI-Stream stage: tkeep masking, per-packet half-word op, one stage register and an FWFT FIFO.
// Define AXIS_HS_STATS_EN to build the saturating beat/packet counters.
module axis_half_sum_fifo import axis_hs_pkg::*; #(
  parameter int TDATA_WIDTH = 64,
  parameter int TDATA_BYTES = TDATA_WIDTH / 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic [1:0]                    mode,
  input  logic [TDATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [TDATA_BYTES-1:0]        s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic [TDATA_BYTES-1:0]        m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [AXIS_HS_STATS_W-1:0]    pkt_count,
  output logic [AXIS_HS_STATS_W-1:0]    beat_count,
  output logic [3:0]                    leds_4bits_tri_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW:0] DEPTH_CREDITS = (LW+1)'(FIFO_DEPTH);

  logic                   accept;
  logic                   pkt_start;
  logic [1:0]             mode_lat;
  logic [1:0]             mode_eff;
  logic [TDATA_WIDTH-1:0] masked;
  logic [TDATA_WIDTH-1:0] result;
  logic                   stage_valid;
  logic                   stage_last;
  logic [TDATA_WIDTH-1:0] stage_data;
  logic [TDATA_WIDTH:0]   head;
  logic [LW:0]            credit_used;
  logic                   led_toggle;

  always_comb begin
    masked = '0;
    for (int i = 0; i < TDATA_BYTES; i++)
      masked[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
  end

  // The first beat of a packet uses the live mode; later beats reuse the latched one.
  assign mode_eff = pkt_start ? mode : mode_lat;
  assign result   = TDATA_WIDTH'(axis_hs_apply(mode_eff, axis_hs_word_t'(masked), TDATA_WIDTH));

  // Credits count the stage slot too, so a beat in flight always has a FIFO entry waiting.
  assign credit_used   = {1'b0, fifo_level} + {{LW{1'b0}}, stage_valid};
  assign s_axis_tready = !s_axis_areset && (credit_used < DEPTH_CREDITS);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      pkt_start   <= 1'b1;
      mode_lat    <= AXIS_HS_MODE_PASS;
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
      stage_data  <= '0;
      led_toggle  <= 1'b0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_data <= result;
        stage_last <= s_axis_tlast;
        pkt_start  <= s_axis_tlast;
        if (pkt_start) mode_lat <= mode;
        if (s_axis_tlast) led_toggle <= ~led_toggle;
      end
    end
  end

  axis_hs_sync_fifo #(
    .WIDTH (TDATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (s_axis_aclk),
    .rst       (s_axis_areset),
    .push      (stage_valid),
    .push_data ({stage_last, stage_data}),
    .pop       (m_axis_tready),
    .head_data (head),
    .level     (fifo_level)
  );

  // Head contents are masked when empty so outputs read zero straight out of reset.
  assign m_axis_tvalid = (fifo_level != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[TDATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[TDATA_WIDTH];
  assign m_axis_tkeep  = '1;

  assign leds_4bits_tri_o = {(mode_lat == AXIS_HS_MODE_ADD) || (mode_lat == AXIS_HS_MODE_XOR),
                             m_axis_tvalid,
                             fifo_level == LW'(FIFO_DEPTH),
                             led_toggle};

`ifdef AXIS_HS_STATS_EN
  logic [AXIS_HS_STATS_W-1:0] beat_q;
  logic [AXIS_HS_STATS_W-1:0] pkt_q;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      beat_q <= '0;
      pkt_q  <= '0;
    end else if (accept) begin
      if (~&beat_q) beat_q <= beat_q + AXIS_HS_STATS_W'(1);
      if (s_axis_tlast && ~&pkt_q) pkt_q <= pkt_q + AXIS_HS_STATS_W'(1);
    end
  end

  assign beat_count = beat_q;
  assign pkt_count  = pkt_q;
`else
  assign beat_count = '0;
  assign pkt_count  = '0;
`endif

endmodule

// File: tb/tb_axis_half_sum_fifo.sv
// Bench for axis_half_sum_fifo: directed beats push expectations into a scoreboard that an
// independent output monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_axis_half_sum_fifo;
  import axis_hs_pkg::*;

  localparam int W  = 64;
  localparam int B  = W / 8;
  localparam int D  = 8;
  localparam int LW = $clog2(D) + 1;

`ifdef AXIS_HS_STATS_EN
  localparam logic [W-1:0] EXP_BEATS = 64'd12;
  localparam logic [W-1:0] EXP_PKTS  = 64'd4;
`else
  localparam logic [W-1:0] EXP_BEATS = 64'd0;
  localparam logic [W-1:0] EXP_PKTS  = 64'd0;
`endif

  logic          s_axis_aclk = 1'b0;
  logic          s_axis_areset;
  logic [1:0]    mode;
  logic [W-1:0]  s_axis_tdata;
  logic [B-1:0]  s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic [B-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [LW-1:0] fifo_level;
  logic [31:0]   pkt_count;
  logic [31:0]   beat_count;
  logic [3:0]    leds;

  int checks    = 0;
  int failures  = 0;
  int pop_count = 0;
  logic [W:0] sb [$];
  logic [W:0] mon_exp;

  always #5 s_axis_aclk = ~s_axis_aclk;

  axis_half_sum_fifo #(
    .TDATA_WIDTH (W),
    .TDATA_BYTES (B),
    .FIFO_DEPTH  (D)
  ) dut (
    .s_axis_aclk      (s_axis_aclk),
    .s_axis_areset    (s_axis_areset),
    .mode             (mode),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .fifo_level       (fifo_level),
    .pkt_count        (pkt_count),
    .beat_count       (beat_count),
    .leds_4bits_tri_o (leds)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Called at posedge+1; holds the beat until accepted, then records the expected output.
  task automatic applyStimulus(input logic [W-1:0] data, input logic [B-1:0] keep, input logic last,
                               input logic [1:0] md, input logic [W-1:0] exp_data);
    logic accepted;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    mode          = md;
    s_axis_tvalid = 1'b1;
    accepted      = 1'b0;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge s_axis_aclk);
      accepted = s_axis_tready;
      @(posedge s_axis_aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!accepted) reportTimeout("accept");
    else sb.push_back({last, exp_data});
  endtask

  task automatic waitDrain(input string name);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge s_axis_aclk);
      #1;
      if (fifo_level == '0 && sb.size() == 0) break;
    end
    checkOutput({name, "_drain_level"}, W'(fifo_level), '0);
    checkOutput({name, "_drain_sb"}, W'(sb.size()), '0);
  endtask

  task automatic resetDut();
    s_axis_areset = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge s_axis_aclk);
    #1 s_axis_areset = 1'b0;
    sb.delete();
    @(posedge s_axis_aclk);
    #1;
  endtask

  always @(negedge s_axis_aclk) begin
    if (!s_axis_areset && m_axis_tvalid && m_axis_tready) begin
      pop_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no output", m_axis_tdata);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("out_data", m_axis_tdata, mon_exp[W-1:0]);
        checkOutput("out_last", W'(m_axis_tlast), W'(mon_exp[W]));
        checkOutput("out_keep", W'(m_axis_tkeep), W'(8'hFF));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  start_pops;
    logic any_ready;
    s_axis_areset = 1'b1;
    mode          = AXIS_HS_MODE_PASS;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    checkOutput("inrst_tready", W'(s_axis_tready), '0);
    checkOutput("inrst_tvalid", W'(m_axis_tvalid), '0);
    resetDut();
    checkOutput("rst_tready", W'(s_axis_tready), W'(1));
    checkOutput("rst_level", W'(fifo_level), '0);
    checkOutput("rst_leds", W'(leds), '0);
    checkOutput("rst_beats", W'(beat_count), '0);

    // Add with carry out of the lower half, plus two-cycle latency and LED checks
    applyStimulus(64'h00000001_FFFFFFFF, 8'hFF, 1'b1, AXIS_HS_MODE_ADD, 64'hFFFFFFFF_00000000);
    checkOutput("lat_edge_n", W'(m_axis_tvalid), '0);
    checkOutput("led0_toggle", W'(leds[0]), W'(1));
    checkOutput("led3_add", W'(leds[3]), W'(1));
    @(posedge s_axis_aclk);
    #1;
    checkOutput("lat_edge_n1", W'(m_axis_tvalid), W'(1));
    checkOutput("add_head", m_axis_tdata, 64'hFFFFFFFF_00000000);
    waitDrain("add");

    // Masking, mode 3 as pass, xor with partial keep, add without carry
    applyStimulus(64'h11223344_55667788, 8'h0F, 1'b1, AXIS_HS_MODE_PASS, 64'h00000000_55667788);
    applyStimulus(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 2'd3, 64'hDEADBEEF_CAFEF00D);
    checkOutput("led3_mode3", W'(leds[3]), '0);
    applyStimulus(64'hAABBCCDD_11223344, 8'hF0, 1'b1, AXIS_HS_MODE_XOR, 64'h00000000_AABBCCDD);
    applyStimulus(64'h00000003_00000004, 8'hFF, 1'b1, AXIS_HS_MODE_ADD, 64'h00000000_00000007);
    waitDrain("patterns");

    // Mode changes mid-packet are ignored until the next packet starts
    applyStimulus(64'h0F0F0F0F_000000FF, 8'hFF, 1'b0, AXIS_HS_MODE_XOR, 64'h00000000_0F0F0FF0);
    applyStimulus(64'h12345678_11111111, 8'hFF, 1'b0, AXIS_HS_MODE_ADD, 64'h00000000_03254769);
    applyStimulus(64'hFFFF0000_0000FFFF, 8'hFF, 1'b1, AXIS_HS_MODE_ADD, 64'h00000000_FFFFFFFF);
    applyStimulus(64'h80000000_80000000, 8'hFF, 1'b1, AXIS_HS_MODE_ADD, 64'hFFFFFFFF_00000000);
    waitDrain("midpkt");

    // Backpressure: exactly D beats fit, then input stays blocked
    m_axis_tready = 1'b0;
    for (int i = 0; i < D; i++)
      applyStimulus(64'h1000 + 64'(i), 8'hFF, i == D - 1, AXIS_HS_MODE_PASS, 64'h1000 + 64'(i));
    s_axis_tdata  = 64'hBAD0;
    s_axis_tvalid = 1'b1;
    any_ready     = 1'b0;
    repeat (10) begin
      @(negedge s_axis_aclk);
      any_ready = any_ready | s_axis_tready;
    end
    @(posedge s_axis_aclk);
    #1 s_axis_tvalid = 1'b0;
    checkOutput("bp_tready_low", W'(any_ready), '0);
    checkOutput("bp_level_full", W'(fifo_level), W'(D));
    checkOutput("bp_led_full", W'(leds[1]), W'(1));
    checkOutput("bp_led_valid", W'(leds[2]), W'(1));
    start_pops    = pop_count;
    m_axis_tready = 1'b1;
    repeat (D) @(posedge s_axis_aclk);
    #1;
    checkOutput("bp_drain_pops", W'(pop_count - start_pops), W'(D));
    checkOutput("bp_drain_empty", W'(fifo_level), '0);
    waitDrain("bp");

    // Reset with entries queued mid-packet
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++)
      applyStimulus(64'h5000 + 64'(i), 8'hFF, 1'b0, AXIS_HS_MODE_ADD, 64'h0);
    repeat (2) @(posedge s_axis_aclk);
    #1;
    checkOutput("mid_level5", W'(fifo_level), W'(5));
    #2 s_axis_areset = 1'b1;
    #1;
    checkOutput("mid_rst_tvalid", W'(m_axis_tvalid), '0);
    checkOutput("mid_rst_level", W'(fifo_level), '0);
    checkOutput("mid_rst_tready", W'(s_axis_tready), '0);
    checkOutput("mid_rst_tdata", m_axis_tdata, '0);
    sb.delete();
    @(posedge s_axis_aclk);
    #1 s_axis_areset = 1'b0;
    @(posedge s_axis_aclk);
    #1;
    checkOutput("mid_post_tready", W'(s_axis_tready), W'(1));
    m_axis_tready = 1'b1;
    applyStimulus(64'h0000FFFF_0000F0F0, 8'hFF, 1'b1, AXIS_HS_MODE_XOR, 64'h00000000_00000F0F);
    waitDrain("mid_rst");

    // Statistics: four three-beat packets from a clean reset
    resetDut();
    m_axis_tready = 1'b1;
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 3; b++)
        applyStimulus(64'(p * 16 + b), 8'hFF, b == 2, AXIS_HS_MODE_PASS, 64'(p * 16 + b));
    waitDrain("stats");
    checkOutput("beat_count", W'(beat_count), EXP_BEATS);
    checkOutput("pkt_count", W'(pkt_count), EXP_PKTS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
